// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
// Optional statistics are enabled by defining FIFO_RD_STREAM_STATS_EN.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;
  typedef logic [1:0] ptr_t;

  // Ring pointers count 0,1,2 and wrap back to 0.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry register ring feeding the output stream; head is registered
// storage so the output never depends combinationally on the FIFO data.
module fifo_rd_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  logic [P_DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [P_DATA_WIDTH-1:0] head,
  output occ_t                    occ
);

  logic [P_DATA_WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t                    wr_ptr;
  ptr_t                    rd_ptr;

  // NOTE: storage is reset as well, because the head entry drives m_data_o
  // directly and that output must read zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO pop interface to registered valid/ready stream, hiding FWFT or
// registered-read latency. Define FIFO_RD_STREAM_STATS_EN for beat/stall counters.
module fifo_rd_stream_adapter
  import fifo_rd_stream_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_FWFT       = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fifo_empty_i,
  input  logic [P_DATA_WIDTH-1:0] fifo_data_i,
  output logic                    fifo_rd_o,
  output logic                    m_valid_o,
  output logic [P_DATA_WIDTH-1:0] m_data_o,
  input  logic                    m_ready_i,
  output logic [1:0]              occ_o
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]             beats_o,
  output logic [31:0]             stall_o
`endif
);

  occ_t       occ;
  logic       inflight;
  logic       push;
  logic       pop;
  logic [2:0] committed;

  // NOTE: the pop request looks only at registered state and fifo_empty_i;
  // reserving a slot for every in-flight word means m_ready_i never needs to
  // reach fifo_rd_o, which keeps the ready path short at full throughput.
  assign committed = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_o = ~rst_i & ~fifo_empty_i & (committed < 3'(BUF_DEPTH));

  assign m_valid_o = (occ != 2'd0);
  assign pop       = m_valid_o & m_ready_i;
  assign occ_o     = occ;

  generate
    if (P_FWFT != 0) begin : g_fwft
      assign inflight = 1'b0;
      assign push     = fifo_rd_o;
    end else begin : g_registered_read
      // Data returns one cycle after the pop, so the pop is tracked until then.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          inflight <= 1'b0;
        end else begin
          inflight <= fifo_rd_o;
        end
      end
      assign push = inflight;
    end
  endgenerate

  fifo_rd_buf #(
    .P_DATA_WIDTH(P_DATA_WIDTH)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (fifo_data_i),
    .pop       (pop),
    .head      (m_data_o),
    .occ       (occ)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beats_o <= '0;
      stall_o <= '0;
    end else begin
      if (pop) begin
        beats_o <= beats_o + 32'd1;
      end
      if (m_valid_o & ~m_ready_i) begin
        stall_o <= stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench driving one registered-read and one FWFT adapter from
// behavioural FIFO models with a shared downstream ready.
module tb_fifo_rd_stream_adapter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic       empty0, empty1;
  logic [7:0] fdata0, fdata1;
  logic       rd0, rd1, valid0, valid1;
  logic [7:0] mdata0, mdata1;
  logic [1:0] occ0, occ1;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beats0, beats1, stall0, stall1;
`endif

  // Instance 0: registered-read FIFO, instance 1: FWFT FIFO.
  fifo_rd_stream_adapter #(.P_DATA_WIDTH(8), .P_FWFT(0)) u_nfwft (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty0), .fifo_data_i(fdata0),
    .fifo_rd_o(rd0), .m_valid_o(valid0), .m_data_o(mdata0),
    .m_ready_i(ready), .occ_o(occ0)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beats_o(beats0), .stall_o(stall0)
`endif
  );

  fifo_rd_stream_adapter #(.P_DATA_WIDTH(8), .P_FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty1), .fifo_data_i(fdata1),
    .fifo_rd_o(rd1), .m_valid_o(valid1), .m_data_o(mdata1),
    .m_ready_i(ready), .occ_o(occ1)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beats_o(beats1), .stall_o(stall1)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] fq0[$], fq1[$], exp0[$], exp1[$];
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   pops0, pops1, hs0, hs1, cyc;
  int   first0, first1, last0, last1;
  logic infl0, rd_s0, rd_s1;
  logic pv0, pv1, pr0, pr1;
  logic [7:0] pd0, pd1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
  endtask

  task automatic refresh_fifo();
    empty0 = (fq0.size() == 0);
    empty1 = (fq1.size() == 0);
    fdata1 = empty1 ? 8'h00 : fq1[0];
  endtask

  task automatic reset_model();
    fq0.delete(); fq1.delete(); exp0.delete(); exp1.delete();
    pops0 = 0; pops1 = 0; hs0 = 0; hs1 = 0;
    infl0 = 1'b0; rd_s0 = 1'b0; rd_s1 = 1'b0;
    pv0 = 1'b0; pv1 = 1'b0; pr0 = 1'b0; pr1 = 1'b0; pd0 = '0; pd1 = '0;
    fdata0 = 8'h00;
    refresh_fifo();
  endtask

  task automatic push_word(input logic [7:0] d);
    fq0.push_back(d); fq1.push_back(d);
    exp0.push_back(d); exp1.push_back(d);
    refresh_fifo();
  endtask

  // Mid-cycle sample: occupancy model, pop rule, hold rule and scoreboard.
  task automatic sample();
    int e0, e1;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      e0 = pops0 - hs0 - int'(infl0);
      e1 = pops1 - hs1;
      check("occ_nfwft", 32'(occ0), 32'(e0));
      check("occ_fwft", 32'(occ1), 32'(e1));
      check("valid_nfwft", 32'(valid0), 32'(e0 != 0));
      check("valid_fwft", 32'(valid1), 32'(e1 != 0));
      check("rd_nfwft", 32'(rd0), 32'(!empty0 && (e0 + int'(infl0) < 3)));
      check("rd_fwft", 32'(rd1), 32'(!empty1 && (e1 < 3)));
      if (pv0 && !pr0) begin
        check("hold_valid_nfwft", 32'(valid0), 32'(1));
        check("hold_data_nfwft", 32'(mdata0), 32'(pd0));
      end
      if (pv1 && !pr1) begin
        check("hold_valid_fwft", 32'(valid1), 32'(1));
        check("hold_data_fwft", 32'(mdata1), 32'(pd1));
      end
      if (valid0 && ready) begin
        if (exp0.size() == 0) check("sb_extra_nfwft", 32'(exp0.size()), 32'(1));
        else check("sb_nfwft", 32'(mdata0), 32'(exp0.pop_front()));
        hs0++; last0 = cyc; if (first0 < 0) first0 = cyc;
      end
      if (valid1 && ready) begin
        if (exp1.size() == 0) check("sb_extra_fwft", 32'(exp1.size()), 32'(1));
        else check("sb_fwft", 32'(mdata1), 32'(exp1.pop_front()));
        hs1++; last1 = cyc; if (first1 < 0) first1 = cyc;
      end
      pv0 = valid0; pr0 = ready; pd0 = mdata0;
      pv1 = valid1; pr1 = ready; pd1 = mdata1;
      rd_s0 = rd0; rd_s1 = rd1;
    end
  endtask

  // Just after the edge: the FIFO models act on the pops seen at that edge.
  task automatic advance();
    @(posedge clk);
    #1;
    if (rd_s0 && fq0.size() != 0) begin fdata0 = fq0.pop_front(); pops0++; end
    if (rd_s1 && fq1.size() != 0) begin void'(fq1.pop_front()); pops1++; end
    infl0 = rd_s0;
    rd_s0 = 1'b0; rd_s1 = 1'b0;
    refresh_fifo();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic drain(input string tag, input int budget, input bit rnd);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
      cycle();
      if (rnd) ready = 1'($urandom_range(0, 1));
      n++;
    end
    check(tag, 32'(exp0.size() + exp1.size()), 32'(0));
    ready = 1'b1;
    cycle(); cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, n;
    cyc = 0; first0 = -1; first1 = -1; last0 = 0; last1 = 0;
    reset_model();

    // Test 1: word waiting during reset, single-word latency per mode.
    push_word(8'hA5);
    sample();
    check("rst_rd_nfwft", 32'(rd0), 32'(0));
    check("rst_rd_fwft", 32'(rd1), 32'(0));
    check("rst_valid_nfwft", 32'(valid0), 32'(0));
    check("rst_valid_fwft", 32'(valid1), 32'(0));
    check("rst_data_nfwft", 32'(mdata0), 32'(0));
    check("rst_data_fwft", 32'(mdata1), 32'(0));
    check("rst_occ_nfwft", 32'(occ0), 32'(0));
    check("rst_occ_fwft", 32'(occ1), 32'(0));
    advance();
    rst = 1'b0; ready = 1'b1;
    sample();
    check("t1_n_rd_nfwft", 32'(rd0), 32'(1));
    check("t1_n_rd_fwft", 32'(rd1), 32'(1));
    check("t1_n_valid_nfwft", 32'(valid0), 32'(0));
    check("t1_n_valid_fwft", 32'(valid1), 32'(0));
    advance();
    sample();
    check("t1_n1_valid_fwft", 32'(valid1), 32'(1));
    check("t1_n1_data_fwft", 32'(mdata1), 32'hA5);
    check("t1_n1_valid_nfwft", 32'(valid0), 32'(0));
    advance();
    sample();
    check("t1_n2_valid_nfwft", 32'(valid0), 32'(1));
    check("t1_n2_data_nfwft", 32'(mdata0), 32'hA5);
    check("t1_n2_valid_fwft", 32'(valid1), 32'(0));
    advance();
    sample();
    check("t1_n3_valid_nfwft", 32'(valid0), 32'(0));
    check("t1_n3_occ_nfwft", 32'(occ0), 32'(0));
    check("t1_n3_occ_fwft", 32'(occ1), 32'(0));
    advance();

    // Test 2: 0x01..0x10 back to back, no gap after the first word.
    h0 = hs0; h1 = hs1; first0 = -1; first1 = -1;
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    drain("t2_drain", 60, 1'b0);
    check("t2_beats_nfwft", 32'(hs0 - h0), 32'(16));
    check("t2_beats_fwft", 32'(hs1 - h1), 32'(16));
    check("t2_span_nfwft", 32'(last0 - first0), 32'(15));
    check("t2_span_fwft", 32'(last1 - first1), 32'(15));

    // Test 3: downstream stalled, buffer fills to 3 and stops popping.
    ready = 1'b0;
    h0 = hs0; h1 = hs1;
    for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
    repeat (8) cycle();
    sample();
    check("t3_occ_nfwft", 32'(occ0), 32'(3));
    check("t3_occ_fwft", 32'(occ1), 32'(3));
    check("t3_rd_nfwft", 32'(rd0), 32'(0));
    check("t3_rd_fwft", 32'(rd1), 32'(0));
    check("t3_head_nfwft", 32'(mdata0), 32'h20);
    check("t3_head_fwft", 32'(mdata1), 32'h20);
    check("t3_left_nfwft", 32'(fq0.size()), 32'(5));
    check("t3_left_fwft", 32'(fq1.size()), 32'(5));
    advance();
    ready = 1'b1;
    drain("t3_drain", 60, 1'b0);
    check("t3_beats_nfwft", 32'(hs0 - h0), 32'(8));
    check("t3_beats_fwft", 32'(hs1 - h1), 32'(8));

    // Test 4: 1000 random words under random backpressure.
    h0 = hs0; h1 = hs1;
    for (int i = 0; i < 1000; i++) push_word(8'($urandom_range(0, 255)));
    ready = 1'($urandom_range(0, 1));
    drain("t4_drain", 8000, 1'b1);
    check("t4_beats_nfwft", 32'(hs0 - h0), 32'(1000));
    check("t4_beats_fwft", 32'(hs1 - h1), 32'(1000));

    // Test 5: reset with two words buffered and one in flight.
    ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'h40 + 8'(i));
    n = 0;
    sample();
    while (occ0 != 2'd2 && n < 10) begin
      advance(); sample(); n++;
    end
    check("t5_setup_occ", 32'(occ0), 32'(2));
    check("t5_setup_rd", 32'(rd0), 32'(0));
    rst = 1'b1;
    #1;
    check("t5_valid_nfwft", 32'(valid0), 32'(0));
    check("t5_valid_fwft", 32'(valid1), 32'(0));
    check("t5_occ_nfwft", 32'(occ0), 32'(0));
    check("t5_occ_fwft", 32'(occ1), 32'(0));
    check("t5_rd_nfwft", 32'(rd0), 32'(0));
    check("t5_rd_fwft", 32'(rd1), 32'(0));
    reset_model();
    advance(); advance();
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'h50 + 8'(i));
    drain("t5_drain", 60, 1'b0);
    check("t5_beats_nfwft", 32'(hs0), 32'(8));
    check("t5_beats_fwft", 32'(hs1), 32'(8));

`ifdef FIFO_RD_STREAM_STATS_EN
    // Test 6: counters clear on reset, then 20 beats with a stalled start.
    rst = 1'b1;
    reset_model();
    #1;
    check("t6_rst_beats_nfwft", beats0, 32'd0);
    check("t6_rst_beats_fwft", beats1, 32'd0);
    check("t6_rst_stall_nfwft", stall0, 32'd0);
    check("t6_rst_stall_fwft", stall1, 32'd0);
    advance();
    rst = 1'b0; ready = 1'b0;
    for (int i = 0; i < 20; i++) push_word(8'h60 + 8'(i));
    repeat (6) cycle();
    ready = 1'b1;
    drain("t6_drain", 80, 1'b0);
    sample();
    check("t6_beats_nfwft", beats0, 32'd20);
    check("t6_beats_fwft", beats1, 32'd20);
    check("t6_stall_nfwft", stall0, 32'd4);
    check("t6_stall_fwft", stall1, 32'd5);
    advance();
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
Downstream read-side stage for sync_fifo_core. Turns the FIFO pop interface (empty_o / rd_i / data_o) into a registered valid/ready stream for the switch egress path. Hides the FIFO read latency (FWFT or non-FWFT) behind a 3-entry internal buffer. Sustains 1 word/cycle with no combinational path from m_ready_i to fifo_rd_o.

Parameters:
P_DATA_WIDTH, 8, word width; must match the connected FIFO.
P_FWFT, 1, FIFO mode: 1 = data valid in the same cycle as rd; 0 = data valid the cycle after rd.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
fifo_empty_i  in  1  FIFO empty_o
fifo_data_i  in  P_DATA_WIDTH  FIFO data_o
fifo_rd_o  out  1  FIFO rd_i (pop)
m_valid_o  out  1  output word valid
m_data_o  out  P_DATA_WIDTH  output word
m_ready_i  in  1  downstream accepts word
occ_o  out  2  buffer occupancy, 0..3

Behaviour:
- Reset values: fifo_rd_o=0, m_valid_o=0, m_data_o=0, occ_o=0. In-flight tracking is cleared and buffer pointers are reset to 0.
- fifo_rd_o = ~rst_i & ~fifo_empty_i & (occ + inflight < 3). This is combinational from registered state and fifo_empty_i only.
- Transfer rules:
  - Push: FWFT: fifo_data_i is written into the buffer at the edge ending the cycle in which fifo_rd_o=1. Non-FWFT: the inflight flop is set by fifo_rd_o, and fifo_data_i is written at the edge ending the next cycle (inflight=1).
  - Pop: a word leaves when m_valid_o & m_ready_i. m_valid_o = (occ != 0). m_data_o = head entry, registered storage with no bypass.
- Latency from fifo_rd_o=1 in cycle N to m_valid_o: N+1 for FWFT, N+2 for non-FWFT (buffer initially empty).
- Simultaneous push and pop: occ is unchanged, and both pointers advance.
- Pointers: 2-bit, wrap 2 to 0 (mod-3 ring).
- Full: occ + inflight = 3 holds fifo_rd_o low. The buffer never overflows.
- Empty: m_valid_o=0. m_data_o holds its last value and is don't-care.
- Throughput: a continuous m_ready_i=1 with a non-empty FIFO gives m_valid_o=1 every cycle after the initial latency, in both modes.
- m_ready_i low: the buffer fills to 3, then fifo_rd_o drops. No data is lost or reordered.
- m_data_o is stable while m_valid_o=1 and m_ready_i=0. Once asserted, m_valid_o stays high until accepted.
- Reset mid-operation: all state clears immediately (async) and buffered/in-flight words are discarded. The FIFO shares rst_i, so streams restart clean.

Optional Feature:
Macro FIFO_RD_STREAM_STATS_EN.
- Defined:
  - Extra output beats_o (32 bits) counts m_valid_o & m_ready_i handshakes, wraps at 2^32, reset 0.
  - Extra output stall_o (32 bits) counts cycles with m_valid_o=1 & m_ready_i=0, wraps, reset 0.
- Not defined: neither port nor any counter exists. Core behaviour is identical.

Decomposition:
- Package fifo_rd_stream_pkg:
  - localparam BUF_DEPTH=3
  - occupancy type (2-bit)
  - pointer type (2-bit)
  - pointer-increment-mod-3 function
- One sub-module, fifo_rd_buf: the 3-entry register ring.
  - Inputs: push, push_data, pop.
  - Outputs: head data, occ.
- The top level holds the inflight flop, the fifo_rd_o logic and the optional stats.

Test Plan:
1. Reset with FIFO holding 0xA5 (non-FWFT), release rst_i, m_ready_i=1 -> fifo_rd_o=1 cycle N; m_valid_o=1 with m_data_o=0xA5 in cycle N+2 only; occ_o returns to 0.
2. Stream 0x01..0x10 through the FIFO, m_ready_i=1 constantly, both P_FWFT values -> output sequence 0x01..0x10 in order with no gap cycles after the first word.
3. m_ready_i=0 with 8 words queued -> occ_o reaches 3, fifo_rd_o=0 thereafter; m_data_o holds first word; raise m_ready_i -> all 8 words emerge in order.
4. Random m_ready_i (50%) over 1000 random words, scoreboard compare -> zero mismatches, no m_valid_o drop without handshake, occ_o never > 3.
5. Assert rst_i mid-stream with occ_o=2 and inflight=1 -> m_valid_o=0, occ_o=0, fifo_rd_o=0 immediately (before next edge); post-reset words from the refilled FIFO emerge correctly.
6. With FIFO_RD_STREAM_STATS_EN: 20 accepted words, 5 stall cycles -> beats_o=20, stall_o=5; after reset both 0.
